// File: rtl/msg_seq_pkg.sv
// Shared definitions for the message sequencer: state encoding and default widths.
package msg_seq_pkg;

    localparam int IDX_W_DEF  = 6;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_SEND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/msg_sequencer_if.sv
// Bundle of the sequencer's control, ROM and transmitter signals, named from the sequencer's side.
interface msg_sequencer_if #(
    parameter int IDX_W  = msg_seq_pkg::IDX_W_DEF,
    parameter int DATA_W = msg_seq_pkg::DATA_W_DEF
);
    logic              i_start;
    logic [IDX_W-1:0]  i_base;
    logic [IDX_W-1:0]  i_len;
    logic              o_busy;
    logic              o_done;
    logic [IDX_W-1:0]  o_rom_index;
    logic [DATA_W-1:0] i_rom_data;
    logic [DATA_W-1:0] o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready;

    modport master (
        input  i_start, i_base, i_len, i_rom_data, i_tx_ready,
        output o_busy, o_done, o_rom_index, o_tx_data, o_tx_valid
    );

    modport slave (
        output i_start, i_base, i_len, i_rom_data, i_tx_ready,
        input  o_busy, o_done, o_rom_index, o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/msg_sequencer.sv
// Walks a run of ROM characters starting at a latched base index and hands each one
// to a UART transmitter over a valid/ready handshake.
module msg_sequencer
    import msg_seq_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    msg_sequencer_if.master bus
);

    state_t            r_state;
    logic [IDX_W-1:0]  r_index;
    logic [IDX_W-1:0]  r_remain;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] w_rom_data;

    assign w_rom_data = bus.i_rom_data;

    // NOTE: every register here is updated with <= so all of them see the pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state    <= ST_IDLE;
            r_index    <= '0;
            r_remain   <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        if (bus.i_len != '0) begin
                            r_index  <= bus.i_base;
                            r_remain <= bus.i_len;
                            r_busy   <= 1'b1;
                            r_state  <= ST_FETCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                // ROM registers its output during this cycle; index must not move.
                ST_FETCH: r_state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    r_tx_data  <= w_rom_data;
                    r_tx_valid <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (r_tx_valid && bus.i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        if (r_remain > IDX_W'(1)) begin
                            r_remain <= r_remain - IDX_W'(1);
                            r_index  <= r_index + IDX_W'(1);
                            r_state  <= ST_FETCH;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_rom_index = r_index;
    assign bus.o_tx_data   = r_tx_data;
    assign bus.o_tx_valid  = r_tx_valid;

endmodule

// File: tb/tb_msg_sequencer.sv
// Scoreboard bench for msg_sequencer: a ROM model, random/directed messages, and a
// monitor that checks every transfer and completion against expected queues.
module tb_msg_sequencer;
    import msg_seq_pkg::*;

    localparam int IDX_W  = 6;
    localparam int DATA_W = 8;
    localparam int ROM_N  = 1 << IDX_W;
    localparam int LIMIT  = 3000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    msg_sequencer_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

    msg_sequencer #(.IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus.master)
    );

    // Character ROM with one cycle of read latency.
    logic [DATA_W-1:0] rom [ROM_N];
    always @(posedge clk) bus.i_rom_data <= rom[bus.o_rom_index];

    logic rand_ready = 1'b0;
    logic ready_val  = 1'b1;
    logic rnd_bit    = 1'b1;
    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end
    assign bus.i_tx_ready = rand_ready ? rnd_bit : ready_val;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    done_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_xfers  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: a message is just the next len ROM cells, wrapping at the top.
    task automatic push_msg(input int base, input int len);
        logic [IDX_W-1:0] idx;
        for (int k = 0; k < len; k++) begin
            idx = IDX_W'((base + k) % ROM_N);
            exp_q.push_back('{idx: idx, data: rom[idx]});
        end
        done_q.push_back(len);
    endtask

    // Monitor
    logic              prev_valid = 1'b0;
    logic              prev_xfer  = 1'b0;
    logic              prev_rstn  = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    beat_t             mon_b;

    always @(negedge clk) begin
        if (rstn) begin
            if (prev_rstn && prev_valid && !prev_xfer) begin
                check("hold_valid", 32'(bus.o_tx_valid), 32'd1);
                check("hold_data", 32'(bus.o_tx_data), 32'(prev_data));
            end
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                n_xfers++;
                if (exp_q.size() == 0) begin
                    flag("unexpected_xfer");
                end else begin
                    mon_b = exp_q.pop_front();
                    check("tx_data", 32'(bus.o_tx_data), 32'(mon_b.data));
                    check("rom_index", 32'(bus.o_rom_index), 32'(mon_b.idx));
                end
            end
            if (bus.o_done) begin
                check("done_not_busy", 32'(bus.o_busy), 32'd0);
                check("done_no_valid", 32'(bus.o_tx_valid), 32'd0);
                if (done_q.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    void'(done_q.pop_front());
                    check("bytes_left_at_done", 32'(exp_q.size()), 32'd0);
                end
            end
        end
        prev_rstn  = rstn;
        prev_valid = bus.o_tx_valid;
        prev_xfer  = bus.o_tx_valid && bus.i_tx_ready;
        prev_data  = bus.o_tx_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.o_busy || bus.o_done) && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) flag("timeout_wait_idle");
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.o_done && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) flag("timeout_wait_done");
        tick();
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.o_tx_valid && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) flag("timeout_wait_valid");
    endtask

    // Drives a start in IDLE and returns one time step after the accepting edge.
    task automatic start_msg(input int base, input int len);
        wait_idle();
        bus.i_start = 1'b1;
        bus.i_base  = IDX_W'(base);
        bus.i_len   = IDX_W'(len);
        push_msg(base, len);
        tick();
        bus.i_start = 1'b0;
        bus.i_base  = IDX_W'($urandom);
        bus.i_len   = IDX_W'($urandom);
    endtask

    task automatic stray_start();
        bus.i_start = 1'b1;
        bus.i_base  = '0;
        bus.i_len   = IDX_W'(1);
        tick();
        bus.i_start = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        string s0;
        string s1;
        int    cyc;
        int    xs;
        int    seen;
        int    b;
        int    l;

        for (int i = 0; i < ROM_N; i++) rom[i] = 8'(i * 37 + 11);
        s0 = "HELLO UART TEST";
        s1 = "Setup complete, all ok";
        for (int i = 0; i < s0.len(); i++) rom[i] = s0[i];
        rom[15] = 8'h0D;
        for (int i = 0; i < s1.len(); i++) rom[16 + i] = s1[i];
        rom[38] = 8'h0D;

        bus.i_start = 1'b0;
        bus.i_base  = '0;
        bus.i_len   = '0;
        repeat (3) tick();
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_valid", 32'(bus.o_tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
        check("rst_index", 32'(bus.o_rom_index), 32'd0);
        rstn = 1'b1;
        tick();

        // Full 16-byte message, ready held high: latency and total duration.
        ready_val = 1'b1;
        start_msg(0, 16);
        cyc = 1;
        while (!bus.o_tx_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("first_valid_cycle", 32'(cyc), 32'd3);
        while (!bus.o_done && cyc < 200) begin
            tick();
            cyc++;
        end
        check("done_cycle", 32'(cyc), 32'd49);
        tick();

        // Backpressure on the third byte of a 23-byte message.
        xs = n_xfers;
        start_msg(16, 23);
        seen = 0;
        while ((n_xfers - xs) < 2 && seen < LIMIT) begin
            tick();
            seen++;
        end
        ready_val = 1'b0;
        wait_valid();
        repeat (10) begin
            check("stall_valid", 32'(bus.o_tx_valid), 32'd1);
            check("stall_data", 32'(bus.o_tx_data), 32'h74);
            tick();
        end
        ready_val = 1'b1;
        wait_done();

        // Zero-length message completes immediately with no ROM or transmitter activity.
        start_msg(int'($urandom_range(0, ROM_N - 1)), 0);
        check("zero_len_done", 32'(bus.o_done), 32'd1);
        check("zero_len_valid", 32'(bus.o_tx_valid), 32'd0);
        check("zero_len_busy", 32'(bus.o_busy), 32'd0);
        tick();
        check("zero_len_done_pulse", 32'(bus.o_done), 32'd0);

        // Index wrap-around.
        start_msg(62, 4);
        wait_done();

        // Starts while busy are ignored.
        start_msg(5, 6);
        repeat (4) tick();
        stray_start();
        repeat (6) tick();
        stray_start();
        wait_done();

        // Reset in the middle of SEND.
        ready_val = 1'b0;
        start_msg(10, 8);
        wait_valid();
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("midrst_valid", 32'(bus.o_tx_valid), 32'd0);
        check("midrst_index", 32'(bus.o_rom_index), 32'd0);
        check("midrst_busy", 32'(bus.o_busy), 32'd0);
        check("midrst_done", 32'(bus.o_done), 32'd0);
        check("midrst_tx_data", 32'(bus.o_tx_data), 32'd0);
        exp_q.delete();
        done_q.delete();
        seen = 0;
        repeat (5) begin
            if (bus.o_done) seen++;
            tick();
        end
        check("no_done_after_reset", 32'(seen), 32'd0);
        ready_val = 1'b1;
        start_msg(3, 5);
        wait_done();

        // Random messages with random backpressure and stray starts.
        rand_ready = 1'b1;
        repeat (30) begin
            b = int'($urandom_range(0, ROM_N - 1));
            l = int'($urandom_range(0, 12));
            start_msg(b, l);
            if (l > 2 && $urandom_range(0, 1) == 1) begin
                tick();
                if (bus.o_busy) stray_start();
            end
        end
        wait_idle();
        repeat (3) tick();
        check("final_queues_empty", 32'(exp_q.size() + done_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
